// File: rtl/fetch_decode.sv
// fetch_decode: instruction-side front end.
// Fetch one word, decode and issue it, then wait for exec's next PC.
module fetch_decode #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_pc,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] imm_i_type,
  output logic [XLEN-1:0] imm_s_type,
  output logic [XLEN-1:0] imm_b_type,
  output logic [XLEN-1:0] imm_u_type,
  output logic [XLEN-1:0] imm_j_type,
  output logic            dec_illegal,
  input  logic            pc_valid,
  input  logic [XLEN-1:0] pc_in,
  output logic            trap
);

  typedef enum logic [2:0] {
    S_REQ,
    S_WAIT,
    S_ISSUE,
    S_WAIT_PC,
    S_ERROR
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [31:0]     instr_q;
  logic            illegal_q;
  logic            illegal_op;
  logic            take_pc;

  always_comb begin
    illegal_op = 1'b1;
    unique case (imem_rsp_data[6:0])
      7'h03, 7'h13, 7'h17,
      7'h23, 7'h33, 7'h37,
      7'h63, 7'h67, 7'h6F: illegal_op = 1'b0;
      default:             illegal_op = 1'b1;
    endcase
  end

  // A next PC offered during the issue handshake is taken at once.
  assign take_pc = pc_valid &
                   ((state == S_WAIT_PC) |
                    ((state == S_ISSUE) & dec_ready));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      instr_q   <= '0;
      illegal_q <= 1'b0;
      dec_valid <= 1'b0;
      dec_pc    <= '0;
      trap      <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          if (imem_req_ready)
            state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            instr_q   <= imem_rsp_data;
            illegal_q <= illegal_op;
            dec_pc    <= pc;
            dec_valid <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (dec_ready) begin
            dec_valid <= 1'b0;
            state     <= S_WAIT_PC;
          end
        end
        S_WAIT_PC: ;
        S_ERROR:   ;
        default:   state <= S_ERROR;
      endcase
      if (take_pc) begin
        if (pc_in[1:0] == 2'b00) begin
          pc    <= pc_in;
          state <= S_REQ;
        end else begin
          trap  <= 1'b1;
          state <= S_ERROR;
        end
      end
    end
  end

  // Held low while in reset so nothing escapes before release.
  assign imem_req_valid = rst_n & (state == S_REQ);
  assign imem_addr      = rst_n ? pc : '0;

  assign opcode      = instr_q[6:0];
  assign rd          = instr_q[11:7];
  assign funct3      = instr_q[14:12];
  assign rs1         = instr_q[19:15];
  assign rs2         = instr_q[24:20];
  assign funct7      = instr_q[31:25];
  assign dec_illegal = illegal_q;

  assign imm_i_type = {{(XLEN-12){instr_q[31]}},
                       instr_q[31:20]};
  assign imm_s_type = {{(XLEN-12){instr_q[31]}},
                       instr_q[31:25], instr_q[11:7]};
  assign imm_b_type = {{(XLEN-13){instr_q[31]}},
                       instr_q[31], instr_q[7],
                       instr_q[30:25], instr_q[11:8],
                       1'b0};
  assign imm_u_type = {instr_q[31:12], 12'b0};
  assign imm_j_type = {{(XLEN-21){instr_q[31]}},
                       instr_q[31], instr_q[19:12],
                       instr_q[20], instr_q[30:21],
                       1'b0};

endmodule

// File: tb/tb_fetch_decode.sv
// tb_fetch_decode: directed plus randomized checks of fetch_decode
// against a transaction-level model of the front end.
module tb_fetch_decode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_pc;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;
  logic [31:0] imm_i_type;
  logic [31:0] imm_s_type;
  logic [31:0] imm_b_type;
  logic [31:0] imm_u_type;
  logic [31:0] imm_j_type;
  logic        dec_illegal;
  logic        pc_valid;
  logic [31:0] pc_in;
  logic        trap;

  fetch_decode #(
    .RESET_PC (32'h0000_0000),
    .XLEN     (32)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_pc         (dec_pc),
    .opcode         (opcode),
    .rd             (rd),
    .funct3         (funct3),
    .rs1            (rs1),
    .rs2            (rs2),
    .funct7         (funct7),
    .imm_i_type     (imm_i_type),
    .imm_s_type     (imm_s_type),
    .imm_b_type     (imm_b_type),
    .imm_u_type     (imm_u_type),
    .imm_j_type     (imm_j_type),
    .dec_illegal    (dec_illegal),
    .pc_valid       (pc_valid),
    .pc_in          (pc_in),
    .trap           (trap)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: where the current instruction is in its life.
  // 0 fetch requested, 1 word awaited, 2 offered to exec,
  // 3 next PC awaited, 4 dead after a misaligned PC.
  int          m_phase;
  logic [31:0] m_addr;
  logic [31:0] m_word;
  logic [31:0] m_pc;
  logic        m_trap;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic m_illegal(input logic [31:0] w);
    logic [6:0] op;
    op = w[6:0];
    return !(op inside {7'h03, 7'h13, 7'h17, 7'h23, 7'h33,
                        7'h37, 7'h63, 7'h67, 7'h6F});
  endfunction

  function automatic logic [31:0] m_sign(input logic [31:0] w);
    logic signed [31:0] s;
    s = w;
    return 32'(s >>> 31);
  endfunction

  function automatic logic [31:0] m_imm_i(input logic [31:0] w);
    logic signed [31:0] s;
    s = w;
    return 32'(s >>> 20);
  endfunction

  function automatic logic [31:0] m_imm_s(input logic [31:0] w);
    return (m_sign(w) << 11) | (32'(w[30:25]) << 5)
           | 32'(w[11:7]);
  endfunction

  function automatic logic [31:0] m_imm_b(input logic [31:0] w);
    return (m_sign(w) << 12) | (32'(w[7]) << 11)
           | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
  endfunction

  function automatic logic [31:0] m_imm_j(input logic [31:0] w);
    return (m_sign(w) << 20) | (32'(w[19:12]) << 12)
           | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_addr  = 32'h0;
    m_word  = 32'h0;
    m_pc    = 32'h0;
    m_trap  = 1'b0;
  endtask

  task automatic model_take_pc();
    if (pc_in[1:0] == 2'b00) begin
      m_addr  = pc_in;
      m_phase = 0;
    end else begin
      m_trap  = 1'b1;
      m_phase = 4;
    end
  endtask

  // What the coming rising edge does, given the inputs now driven.
  task automatic model_step();
    case (m_phase)
      0: if (imem_req_ready) m_phase = 1;
      1: if (imem_rsp_valid) begin
        m_word  = imem_rsp_data;
        m_pc    = m_addr;
        m_phase = 2;
      end
      2: if (dec_ready) begin
        if (pc_valid) model_take_pc();
        else m_phase = 3;
      end
      3: if (pc_valid) model_take_pc();
      default: ;
    endcase
  endtask

  task automatic compare();
    check("req_valid", 32'(imem_req_valid), 32'(m_phase == 0));
    if (m_phase == 0) check("imem_addr", imem_addr, m_addr);
    check("dec_valid", 32'(dec_valid), 32'(m_phase == 2));
    check("trap", 32'(trap), 32'(m_trap));
    if (m_phase == 2) begin
      check("dec_pc", dec_pc, m_pc);
      check("opcode", 32'(opcode), 32'(m_word[6:0]));
      check("rd", 32'(rd), 32'(m_word[11:7]));
      check("funct3", 32'(funct3), 32'(m_word[14:12]));
      check("rs1", 32'(rs1), 32'(m_word[19:15]));
      check("rs2", 32'(rs2), 32'(m_word[24:20]));
      check("funct7", 32'(funct7), 32'(m_word[31:25]));
      check("imm_i", imm_i_type, m_imm_i(m_word));
      check("imm_s", imm_s_type, m_imm_s(m_word));
      check("imm_b", imm_b_type, m_imm_b(m_word));
      check("imm_u", imm_u_type, m_word & 32'hFFFF_F000);
      check("imm_j", imm_j_type, m_imm_j(m_word));
      check("illegal", 32'(dec_illegal), 32'(m_illegal(m_word)));
    end
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic idle_inputs();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    dec_ready      = 1'b0;
    pc_valid       = 1'b0;
    pc_in          = 32'h0;
  endtask

  // Asserts reset between edges and checks the asynchronous clear.
  task automatic do_reset();
    #2;
    idle_inputs();
    rst_n = 1'b0;
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_dec_valid", 32'(dec_valid), 32'h0);
    check("rst_trap", 32'(trap), 32'h0);
    check("rst_opcode", 32'(opcode), 32'h0);
    check("rst_imm_j", imm_j_type, 32'h0);
    check("rst_illegal", 32'(dec_illegal), 32'h0);
    check("rst_dec_pc", dec_pc, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    compare();
    check("post_rst_req", 32'(imem_req_valid), 32'h1);
    check("post_rst_addr", imem_addr, 32'h0);
  endtask

  task automatic do_fetch(input logic [31:0] w, input int gap);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    for (int k = 0; k < gap; k++) tick();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = w;
    tick();
    imem_rsp_valid = 1'b0;
  endtask

  task automatic handshake_pc(input logic [31:0] npc);
    dec_ready = 1'b1;
    pc_valid  = 1'b1;
    pc_in     = npc;
    tick();
    dec_ready = 1'b0;
    pc_valid  = 1'b0;
  endtask

  function automatic logic [31:0] rand_word();
    logic [6:0] ops [9];
    logic [31:0] w;
    ops = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33,
            7'h37, 7'h63, 7'h67, 7'h6F};
    w = $urandom;
    if ($urandom_range(0, 3) != 0)
      w[6:0] = ops[$urandom_range(0, 8)];
    return w;
  endfunction

  initial begin
    int dead;
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("init_req_valid", 32'(imem_req_valid), 32'h0);
    check("init_trap", 32'(trap), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    compare();

    // addi x1, x0, 5 with the response two cycles after acceptance
    check("t1_addr", imem_addr, 32'h0);
    do_fetch(32'h0050_0093, 1);
    check("t1_dec_valid", 32'(dec_valid), 32'h1);
    check("t1_opcode", 32'(opcode), 32'h13);
    check("t1_rd", 32'(rd), 32'h1);
    check("t1_funct3", 32'(funct3), 32'h0);
    check("t1_rs1", 32'(rs1), 32'h0);
    check("t1_imm_i", imm_i_type, 32'h0000_0005);
    check("t1_illegal", 32'(dec_illegal), 32'h0);
    handshake_pc(32'h0000_0004);
    check("t1_next_addr", imem_addr, 32'h0000_0004);

    // beq x1, x2, -4; next PC arrives after a WAIT_PC cycle
    do_fetch(32'hFE20_8EE3, 0);
    check("t2_funct3", 32'(funct3), 32'h0);
    check("t2_rs1", 32'(rs1), 32'h1);
    check("t2_rs2", 32'(rs2), 32'h2);
    check("t2_imm_b", imm_b_type, 32'hFFFF_FFFC);
    check("t2_dec_pc", dec_pc, 32'h0000_0004);
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    tick();
    pc_valid = 1'b1;
    pc_in    = 32'h0000_0008;
    tick();
    pc_valid = 1'b0;
    check("t2_next_addr", imem_addr, 32'h0000_0008);

    // lui x5, 0x12345 stalled for five cycles
    do_fetch(32'h1234_52B7, 2);
    for (int k = 0; k < 5; k++) begin
      check("t3_stall_valid", 32'(dec_valid), 32'h1);
      check("t3_opcode", 32'(opcode), 32'h37);
      check("t3_rd", 32'(rd), 32'h5);
      check("t3_imm_u", imm_u_type, 32'h1234_5000);
      tick();
    end
    dec_ready = 1'b1;
    tick();
    check("t3_one_hs", 32'(dec_valid), 32'h0);
    tick();
    check("t3_no_second", 32'(dec_valid), 32'h0);
    dec_ready = 1'b0;
    pc_valid  = 1'b1;
    pc_in     = 32'h0000_000C;
    tick();
    pc_valid = 1'b0;

    // next PC in the handshake cycle skips WAIT_PC
    do_fetch(32'h0000_0013, 0);
    handshake_pc(32'h0000_0010);
    check("t4_req_valid", 32'(imem_req_valid), 32'h1);
    check("t4_addr", imem_addr, 32'h0000_0010);

    // illegal opcode still issues, then a misaligned PC traps
    do_fetch(32'h0000_007F, 0);
    check("t7_illegal", 32'(dec_illegal), 32'h1);
    check("t7_dec_valid", 32'(dec_valid), 32'h1);
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    pc_valid  = 1'b1;
    pc_in     = 32'h0000_0006;
    tick();
    pc_valid = 1'b0;
    check("t5_trap", 32'(trap), 32'h1);
    for (int k = 0; k < 6; k++) begin
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b1;
      dec_ready      = 1'b1;
      tick();
      check("t5_no_req", 32'(imem_req_valid), 32'h0);
    end
    do_reset();

    // request left hanging, then reset without a clock edge
    do_fetch(32'h0000_0013, 0);
    handshake_pc(32'h0000_0040);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t6_held_addr", imem_addr, 32'h0000_0040);
    end
    do_reset();

    // randomized traffic
    dead = 0;
    for (int n = 0; n < 4000; n++) begin
      imem_req_ready = ($urandom_range(0, 1) == 1);
      imem_rsp_valid = ($urandom_range(0, 2) == 0);
      imem_rsp_data  = rand_word();
      dec_ready      = ($urandom_range(0, 2) != 0);
      pc_valid       = ($urandom_range(0, 2) == 0);
      pc_in          = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 39) == 0)
        pc_in[1:0] = 2'($urandom_range(1, 3));
      tick();
      dead = (m_phase == 4) ? dead + 1 : 0;
      if (dead > 5 || $urandom_range(0, 299) == 0) begin
        dead = 0;
        do_reset();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
